// File: rtl/sequenciador_movimentos.sv
// Expands one cube face-turn command into its fixed list of servo primitives and issues them
// one per handshake with the servo manager, with a per-primitive timeout.
module sequenciador_movimentos #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int TIMEOUT_WIDTH  = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_face,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    input  logic       limpa,
    input  logic       pronto_servo,
    output logic       move_servo_peteleco,
    output logic       move_servo_tampa,
    output logic       move_servo_base,
    output logic [1:0] base_dir,
    output logic       ocupado,
    output logic       feito,
    output logic       erro,
    output logic [3:0] db_estado,
    output logic [3:0] db_passo
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0, ST_LOAD = 4'd1, ST_ISSUE = 4'd2, ST_WAIT = 4'd3,
        ST_NEXT = 4'd4, ST_DONE = 4'd5, ST_ERRO = 4'd6
    } state_t;

    typedef enum logic [2:0] {P_FLIP, P_LID, P_TURN, P_YAWP, P_YAWN} prim_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    // Every list brings the cube back to its home orientation, so no state carries over.
    function automatic prim_t rom(input logic [2:0] face, input logic [3:0] step);
        prim_t p;
        p = P_FLIP;
        case (face)
            3'd0: case (step) 4'd2: p = P_LID; 4'd3: p = P_TURN; 4'd4: p = P_LID; default: p = P_FLIP; endcase
            3'd1: case (step) 4'd1: p = P_TURN; default: p = P_LID; endcase
            3'd2: case (step) 4'd1: p = P_LID; 4'd2: p = P_TURN; 4'd3: p = P_LID; default: p = P_FLIP; endcase
            3'd3: case (step) 4'd3: p = P_LID; 4'd4: p = P_TURN; 4'd5: p = P_LID; default: p = P_FLIP; endcase
            3'd4: case (step)
                      4'd0: p = P_YAWN; 4'd2: p = P_LID; 4'd3: p = P_TURN; 4'd4: p = P_LID;
                      4'd8: p = P_YAWP; default: p = P_FLIP;
                  endcase
            default: case (step)
                      4'd0: p = P_YAWP; 4'd2: p = P_LID; 4'd3: p = P_TURN; 4'd4: p = P_LID;
                      4'd8: p = P_YAWN; default: p = P_FLIP;
                  endcase
        endcase
        return p;
    endfunction

    function automatic logic [3:0] seq_len(input logic [2:0] face);
        case (face)
            3'd1:       return 4'd3;
            3'd4, 3'd5: return 4'd9;
            default:    return 4'd7;
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic [2:0]               face_q, face_d;
    logic [1:0]               dir_q, dir_d;
    logic [3:0]               step_q, step_d, len_q, len_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     lid_fechada_q, lid_fechada_d;
    logic                     peteleco_q, peteleco_d, tampa_q, tampa_d, base_q, base_d;
    logic [1:0]               base_dir_q, base_dir_d;
    logic                     feito_q, feito_d, erro_q, erro_d, ocupado_q, ocupado_d;
    prim_t                    cur_prim, nxt_prim;
    logic                     issue;

    always_comb begin
        state_d       = state_q;
        face_d        = face_q;
        dir_d         = dir_q;
        step_d        = step_q;
        len_d         = len_q;
        cnt_d         = '0;
        lid_fechada_d = lid_fechada_q;
        cur_prim      = rom(face_q, step_q);
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                face_d  = cmd_face;
                dir_d   = cmd_dir;
                state_d = (cmd_face > 3'd5 || cmd_dir == 2'd3) ? ST_ERRO : ST_LOAD;
            end
            ST_LOAD: begin
                step_d  = 4'd0;
                len_d   = seq_len(face_q);
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (pronto_servo) begin
                    state_d = ST_NEXT;
                    if (cur_prim == P_LID) lid_fechada_d = ~lid_fechada_q;
                end else if (cnt_d == CNT_LAST) begin
                    state_d = ST_ERRO;
                end
            end
            ST_NEXT: begin
                if (step_q == len_q - 4'd1) begin
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERRO: if (limpa) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state and next step.
        nxt_prim   = rom(face_q, step_d);
        issue      = (state_d == ST_ISSUE);
        peteleco_d = issue && nxt_prim == P_FLIP;
        tampa_d    = issue && nxt_prim == P_LID;
        base_d     = issue && (nxt_prim == P_TURN || nxt_prim == P_YAWP || nxt_prim == P_YAWN);
        base_dir_d = base_dir_q;
        if (base_d) begin
            case (nxt_prim)
                P_YAWP:  base_dir_d = 2'b00;
                P_YAWN:  base_dir_d = 2'b01;
                default: base_dir_d = (dir_q == 2'd0) ? 2'b01 : (dir_q == 2'd1) ? 2'b00 : 2'b10;
            endcase
        end
        feito_d   = (state_d == ST_DONE);
        erro_d    = (state_d == ST_ERRO);
        ocupado_d = (state_d == ST_LOAD) || (state_d == ST_ISSUE) || (state_d == ST_WAIT) ||
                    (state_d == ST_NEXT) || (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            face_q        <= 3'd0;
            dir_q         <= 2'd0;
            step_q        <= 4'd0;
            len_q         <= 4'd0;
            cnt_q         <= '0;
            lid_fechada_q <= 1'b0;
            peteleco_q    <= 1'b0;
            tampa_q       <= 1'b0;
            base_q        <= 1'b0;
            base_dir_q    <= 2'b00;
            feito_q       <= 1'b0;
            erro_q        <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            face_q        <= face_d;
            dir_q         <= dir_d;
            step_q        <= step_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            lid_fechada_q <= lid_fechada_d;
            peteleco_q    <= peteleco_d;
            tampa_q       <= tampa_d;
            base_q        <= base_d;
            base_dir_q    <= base_dir_d;
            feito_q       <= feito_d;
            erro_q        <= erro_d;
            ocupado_q     <= ocupado_d;
        end
    end

    // A face turn completing with the lid open means the lid tracking went out of step.
    turn_needs_closed_lid: assert property (@(posedge clock) disable iff (!reset)
        (state_q == ST_WAIT && pronto_servo && cur_prim == P_TURN) |-> lid_fechada_q);

    assign cmd_ready           = (state_q == ST_IDLE);
    assign move_servo_peteleco = peteleco_q;
    assign move_servo_tampa    = tampa_q;
    assign move_servo_base     = base_q;
    assign base_dir            = base_dir_q;
    assign ocupado             = ocupado_q;
    assign feito               = feito_q;
    assign erro                = erro_q;
    assign db_estado           = state_q;
    assign db_passo            = step_q;

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Directed bench for sequenciador_movimentos: primitive order, handshake latency, errors,
// timeout, async reset mid-command and back-to-back commands.
module tb_sequenciador_movimentos;

    localparam int TO = 16;
    localparam logic [2:0] RF = 3'b100, RL = 3'b010, RB = 3'b001, RN = 3'b000;

    logic       clock = 1'b0, reset = 1'b0, cmd_valid = 1'b0, limpa = 1'b0, pronto_servo = 1'b0;
    logic [2:0] cmd_face = 3'd0;
    logic [1:0] cmd_dir = 2'd0;
    logic       cmd_ready, move_servo_peteleco, move_servo_tampa, move_servo_base;
    logic       ocupado, feito, erro;
    logic [1:0] base_dir;
    logic [3:0] db_estado, db_passo;

    int   n_cmp = 0, n_err = 0;
    logic hold_valid = 1'b0;
    logic [2:0] ep[9];
    logic [1:0] eb[9];
    logic [2:0] reqv;

    assign reqv = {move_servo_peteleco, move_servo_tampa, move_servo_base};

    sequenciador_movimentos #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(27)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_face(cmd_face),
        .cmd_dir(cmd_dir), .cmd_ready(cmd_ready), .limpa(limpa), .pronto_servo(pronto_servo),
        .move_servo_peteleco(move_servo_peteleco), .move_servo_tampa(move_servo_tampa),
        .move_servo_base(move_servo_base), .base_dir(base_dir), .ocupado(ocupado),
        .feito(feito), .erro(erro), .db_estado(db_estado), .db_passo(db_passo)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one command and plays the servo manager: pronto comes dly cycles after each request.
    task automatic do_cmd(input logic [2:0] f, input logic [1:0] d, input int n, input int dly,
                          input int abort_at, input string nm);
        int k;
        cmd_face  = f;
        cmd_dir   = d;
        cmd_valid = 1'b1;
        chk({nm, " ready"}, cmd_ready, 1);
        tick();
        if (!hold_valid) cmd_valid = 1'b0;
        chk({nm, " load"}, db_estado, 1);
        chk({nm, " busy"}, ocupado, 1);
        k = 0;
        while (reqv == RN && k < 5) begin
            tick();
            k++;
        end
        chk({nm, " first_lat"}, k, 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                chk($sformatf("%s gap%0d", nm, i), reqv, RN);
                tick();
            end
            chk($sformatf("%s req%0d", nm, i), reqv, ep[i]);
            chk($sformatf("%s step%0d", nm, i), db_passo, i);
            chk($sformatf("%s notready%0d", nm, i), cmd_ready, 0);
            if (ep[i] == RB) chk($sformatf("%s dir%0d", nm, i), base_dir, eb[i]);
            tick();
            chk($sformatf("%s pulse%0d", nm, i), reqv, RN);
            if (i == abort_at) return;
            repeat (dly - 1) tick();
            if (ep[i] == RB) chk($sformatf("%s dirhold%0d", nm, i), base_dir, eb[i]);
            pronto_servo = 1'b1;
            tick();
            pronto_servo = 1'b0;
        end
        chk({nm, " last_gap"}, reqv, RN);
        tick();
        chk({nm, " feito"}, feito, 1);
        tick();
        chk({nm, " feito_pulse"}, feito, 0);
        chk({nm, " idle"}, db_estado, 0);
        chk({nm, " idle_free"}, ocupado, 0);
    endtask

    initial begin
        int k, nreq, got;
        repeat (2) @(posedge clock);
        #1;
        chk("rst estado", db_estado, 0);
        chk("rst ready", cmd_ready, 1);
        chk("rst outs", {reqv, feito, erro, ocupado, base_dir}, 0);
        reset = 1'b1;
        tick();

        ep = '{RL, RB, RL, RN, RN, RN, RN, RN, RN};
        eb = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        do_cmd(3'd1, 2'd0, 3, 3, -1, "D_cw");

        pronto_servo = 1'b1;
        tick();
        pronto_servo = 1'b0;
        chk("spur estado", db_estado, 0);
        chk("spur req", reqv, RN);
        tick();
        chk("spur req2", {reqv, ocupado}, 0);

        ep = '{RB, RF, RL, RB, RL, RF, RF, RF, RB};
        eb = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        do_cmd(3'd5, 2'd2, 9, 5, -1, "R_half");

        for (int t = 0; t < 2; t++) begin
            cmd_face  = (t == 0) ? 3'd6 : 3'd0;
            cmd_dir   = (t == 0) ? 2'd0 : 2'd3;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("ill%0d erro", t), erro, 1);
            chk($sformatf("ill%0d estado", t), db_estado, 6);
            chk($sformatf("ill%0d ready", t), cmd_ready, 0);
            repeat (3) tick();
            chk($sformatf("ill%0d noreq", t), {reqv, ocupado, erro}, 3'b001);
            limpa = 1'b1;
            tick();
            limpa = 1'b0;
            chk($sformatf("ill%0d clr", t), {erro, cmd_ready}, 2'b01);
            chk($sformatf("ill%0d clr_estado", t), db_estado, 0);
        end

        cmd_face  = 3'd1;
        cmd_dir   = 2'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("to req", reqv, RL);
        k = 0;
        while (!erro && k < 40) begin
            tick();
            k++;
        end
        chk("to latency", k, TO);
        chk("to estado", db_estado, 6);
        chk("to noreq", reqv, RN);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        chk("to clr", db_estado, 0);

        ep = '{RF, RL, RB, RL, RF, RF, RF, RN, RN};
        eb = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        do_cmd(3'd2, 2'd0, 7, 2, 3, "F_rst");
        #2 reset = 1'b0;
        #1;
        chk("arst estado", db_estado, 0);
        chk("arst passo", db_passo, 0);
        chk("arst outs", {reqv, feito, erro, ocupado, base_dir}, 0);
        tick();
        reset = 1'b1;
        tick();

        ep = '{RF, RF, RL, RB, RL, RF, RF, RN, RN};
        eb = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        do_cmd(3'd0, 2'd0, 7, 1, -1, "U_cw");

        ep = '{RL, RB, RL, RN, RN, RN, RN, RN, RN};
        eb = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        hold_valid = 1'b1;
        do_cmd(3'd1, 2'd1, 3, 2, -1, "D_hold");
        chk("hold ready", cmd_ready, 1);
        tick();
        cmd_valid  = 1'b0;
        hold_valid = 1'b0;
        chk("hold second_accept", db_estado, 1);
        nreq = 0;
        got  = 0;
        for (int c = 0; c < 100 && got == 0; c++) begin
            if (reqv != RN) begin
                nreq++;
                tick();
                pronto_servo = 1'b1;
                tick();
                pronto_servo = 1'b0;
            end else if (feito) begin
                got = 1;
            end else begin
                tick();
            end
        end
        chk("hold second_feito", got, 1);
        chk("hold second_nreq", nreq, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
